// File: rtl/fpmul_pkg.sv
// Shared definitions for the binary32 multiplier.
//   - format constants, canonical quiet NaN
//   - fp32_t: packed view of a binary32 word
//   - cls_e:  operand class after subnormal flush
//   - classify(): maps a binary32 word to its class
package fpmul_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS   = 127;
  localparam int STAGES = 4;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  typedef enum logic [1:0] {ZERO, NORM, INF, NAN} cls_e;

  // Subnormals (exp == 0, frac != 0) fold into ZERO: flush-to-zero on input.
  function automatic cls_e classify(fp32_t x);
    cls_e c;
    if (x.exp == '0)
      c = ZERO;
    else if (x.exp == '1)
      c = (x.frac != '0) ? NAN : INF;
    else
      c = NORM;
    return c;
  endfunction

endpackage

// File: rtl/fpmul_round.sv
// Stage-3 combinational normalise + round-to-nearest-even.
//   prod    : 48-bit significand product (1.x * 1.x, so bit 47 or 46 leads)
//   exp_in  : biased exponent before normalisation (signed, 10 bit)
//   sig     : rounded 24-bit significand, hidden bit in sig[23]
//   exp_out : exponent after normalise and rounding carry
// A zero product passes through as sig == 0, which the pack stage reads as zero.
module fpmul_round
  import fpmul_pkg::*;
(
  input  logic [47:0]       prod,
  input  logic signed [9:0] exp_in,
  output logic [FRAC_W:0]   sig,
  output logic signed [9:0] exp_out
);

  logic [FRAC_W:0]   mant;
  logic              guard, rnd, sticky, round_up;
  logic [FRAC_W+1:0] sum;
  logic signed [9:0] exp_n;

  always_comb begin
    mant   = prod[46:23];
    guard  = prod[22];
    rnd    = prod[21];
    sticky = |prod[20:0];
    exp_n  = exp_in;
    if (prod[47]) begin
      mant   = prod[47:24];
      guard  = prod[23];
      rnd    = prod[22];
      sticky = |prod[21:0];
      exp_n  = exp_in + 10'sd1;
    end
    // Ties (guard set, nothing below) go to the even neighbour.
    round_up = guard & (rnd | sticky | mant[0]);
    sum      = {1'b0, mant} + {{(FRAC_W+1){1'b0}}, round_up};
    // Carry out of rounding leaves 1.000..0 one binade up.
    if (sum[FRAC_W+1]) begin
      sig     = sum[FRAC_W+1:1];
      exp_out = exp_n + 10'sd1;
    end else begin
      sig     = sum[FRAC_W:0];
      exp_out = exp_n;
    end
  end

endmodule

// File: rtl/fpmul.sv
// Four-stage pipelined binary32 multiplier, one product per clock.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset, clears every stage
//   FP_A : operand A (binary32)
//   FP_B : operand B (binary32)
//   FP_Z : registered product, valid 4 edges after the operands are sampled
// S1 latch operands, S2 sign/product/exponent sum, S3 normalise+round,
// S4 range check, special override, pack.
module fpmul
  import fpmul_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] FP_A,
  input  logic [31:0] FP_B,
  output logic [31:0] FP_Z
);

  // Stages holding real data since reset; FP_Z stays 0 until S3 is filled.
  logic [STAGES-2:0] vld_pipe;

  // ---------------- S1 ----------------
  fp32_t a1, b1;
  cls_e  cls_a, cls_b;
  logic [FRAC_W:0]   sig_a, sig_b;
  logic [47:0]       prod;
  logic signed [9:0] exp_sum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a1       <= '0;
      b1       <= '0;
      vld_pipe <= '0;
    end else begin
      a1       <= fp32_t'(FP_A);
      b1       <= fp32_t'(FP_B);
      vld_pipe <= {vld_pipe[STAGES-3:0], 1'b1};
    end
  end

  assign cls_a = classify(a1);
  assign cls_b = classify(b1);
  // Non-normal operands contribute a zero significand; their result is
  // decided by class in S4, and zero also falls out of the product itself.
  assign sig_a = (cls_a == NORM) ? {1'b1, a1.frac} : '0;
  assign sig_b = (cls_b == NORM) ? {1'b1, b1.frac} : '0;
  assign prod  = {24'd0, sig_a} * {24'd0, sig_b};
  assign exp_sum = signed'({2'b00, a1.exp}) + signed'({2'b00, b1.exp})
                 - 10'(BIAS);

  // ---------------- S2 ----------------
  logic              sign2;
  cls_e              cls_a2, cls_b2;
  logic [47:0]       prod2;
  logic signed [9:0] exp2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sign2  <= 1'b0;
      cls_a2 <= ZERO;
      cls_b2 <= ZERO;
      prod2  <= '0;
      exp2   <= '0;
    end else begin
      sign2  <= a1.sign ^ b1.sign;
      cls_a2 <= cls_a;
      cls_b2 <= cls_b;
      prod2  <= prod;
      exp2   <= exp_sum;
    end
  end

  logic [FRAC_W:0]   sig_r;
  logic signed [9:0] exp_r;

  fpmul_round u_round (
    .prod    (prod2),
    .exp_in  (exp2),
    .sig     (sig_r),
    .exp_out (exp_r)
  );

  // ---------------- S3 ----------------
  logic              sign3;
  cls_e              cls_a3, cls_b3;
  logic [FRAC_W:0]   sig3;
  logic signed [9:0] exp3;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sign3  <= 1'b0;
      cls_a3 <= ZERO;
      cls_b3 <= ZERO;
      sig3   <= '0;
      exp3   <= '0;
    end else begin
      sign3  <= sign2;
      cls_a3 <= cls_a2;
      cls_b3 <= cls_b2;
      sig3   <= sig_r;
      exp3   <= exp_r;
    end
  end

  // ---------------- S4 ----------------
  logic [31:0] res;
  logic [31:0] inf_s, zero_s;

  assign inf_s  = {sign3, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
  assign zero_s = {sign3, 31'd0};

  always_comb begin
    res = {sign3, exp3[EXP_W-1:0], sig3[FRAC_W-1:0]};
    if (cls_a3 == NAN || cls_b3 == NAN)
      res = QNAN;
    else if ((cls_a3 == INF && cls_b3 == ZERO) || (cls_a3 == ZERO && cls_b3 == INF))
      res = QNAN;
    else if (cls_a3 == INF || cls_b3 == INF)
      res = inf_s;
    else if (cls_a3 == ZERO || cls_b3 == ZERO || !sig3[FRAC_W])
      res = zero_s;
    else if (exp3 >= 10'sd255)
      res = inf_s;
    else if (exp3 <= 10'sd0)
      res = zero_s;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      FP_Z <= '0;
    else
      FP_Z <= vld_pipe[STAGES-2] ? res : '0;
  end

endmodule

// File: tb/tb_fpmul.sv
// Directed bench for fpmul: reset, basic, sign/rounding, specials, range,
// back-to-back throughput and asynchronous reset mid-stream.
// Operands are driven on the falling edge; FP_Z is sampled on the falling edge.
module tb_fpmul;

  logic        clk;
  logic        rst;
  logic [31:0] FP_A, FP_B, FP_Z;

  int total = 0;
  int bad   = 0;

  fpmul dut (
    .clk  (clk),
    .rst  (rst),
    .FP_A (FP_A),
    .FP_B (FP_B),
    .FP_Z (FP_Z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst  = 1'b0;
    FP_A = 32'h4000_0000;
    FP_B = 32'h4040_0000;
    repeat (3) @(negedge clk);
    total++;
    if (FP_Z !== 32'h0) begin
      bad++;
      $display("FAIL reset_hold: got %h want %h", FP_Z, 32'h0);
    end
  endtask

  // Release reset with 2.0 x 3.0 already on the inputs.
  task automatic test_basic();
    rst = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      total++;
      if (c < 4) begin
        if (FP_Z !== 32'h0) begin
          bad++;
          $display("FAIL basic_pre[%0d]: got %h want %h", c, FP_Z, 32'h0);
        end
      end else if (FP_Z !== 32'h40C0_0000) begin
        bad++;
        $display("FAIL basic: got %h want %h", FP_Z, 32'h40C0_0000);
      end
    end
  endtask

  task automatic test_sign_round();
    logic [31:0] va [4] = '{32'h3FC0_0000, 32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0003};
    logic [31:0] vb [4] = '{32'hC020_0000, 32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0000};
    logic [31:0] ve [4] = '{32'hC070_0000, 32'h3F80_0002, 32'h3FC0_0002, 32'h3FC0_0004};
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c >= 4) begin
        total++;
        if (FP_Z !== ve[c-4]) begin
          bad++;
          $display("FAIL sign_round[%0d]: got %h want %h", c-4, FP_Z, ve[c-4]);
        end
      end
      if (c < 4) begin
        FP_A = va[c];
        FP_B = vb[c];
      end
    end
  endtask

  task automatic test_specials();
    logic [31:0] va [4] = '{32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0001, 32'h8000_0000};
    logic [31:0] vb [4] = '{32'h0000_0000, 32'h4000_0000, 32'h3F80_0000, 32'h4000_0000};
    logic [31:0] ve [4] = '{32'h7FC0_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'h8000_0000};
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c >= 4) begin
        total++;
        if (FP_Z !== ve[c-4]) begin
          bad++;
          $display("FAIL specials[%0d]: got %h want %h", c-4, FP_Z, ve[c-4]);
        end
      end
      if (c < 4) begin
        FP_A = va[c];
        FP_B = vb[c];
      end
    end
  endtask

  task automatic test_range();
    logic [31:0] va [3] = '{32'h7F00_0000, 32'h0080_0000, 32'h0000_0001};
    logic [31:0] vb [3] = '{32'h7F00_0000, 32'h0080_0000, 32'h7F00_0000};
    logic [31:0] ve [3] = '{32'h7F80_0000, 32'h0000_0000, 32'h0000_0000};
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c >= 4) begin
        total++;
        if (FP_Z !== ve[c-4]) begin
          bad++;
          $display("FAIL range[%0d]: got %h want %h", c-4, FP_Z, ve[c-4]);
        end
      end
      if (c < 3) begin
        FP_A = va[c];
        FP_B = vb[c];
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] va [8] = '{32'h4000_0000, 32'h3FC0_0000, 32'h3F80_0000, 32'hC000_0000,
                            32'h3F00_0000, 32'h4040_0000, 32'h3F80_0001, 32'h3FC0_0000};
    logic [31:0] vb [8] = '{32'h4040_0000, 32'hC020_0000, 32'h3F80_0000, 32'hC000_0000,
                            32'h3F00_0000, 32'h4040_0000, 32'h3F80_0001, 32'h3FC0_0000};
    logic [31:0] ve [8] = '{32'h40C0_0000, 32'hC070_0000, 32'h3F80_0000, 32'h4080_0000,
                            32'h3E80_0000, 32'h4110_0000, 32'h3F80_0002, 32'h4010_0000};
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c >= 4) begin
        total++;
        if (FP_Z !== ve[c-4]) begin
          bad++;
          $display("FAIL back_to_back[%0d]: got %h want %h", c-4, FP_Z, ve[c-4]);
        end
      end
      if (c < 8) begin
        FP_A = va[c];
        FP_B = vb[c];
      end
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] va [4] = '{32'h4000_0000, 32'h3FC0_0000, 32'h4040_0000, 32'hC000_0000};
    logic [31:0] vb [4] = '{32'h4040_0000, 32'h3FC0_0000, 32'h4040_0000, 32'hC000_0000};
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      FP_A = va[c];
      FP_B = vb[c];
    end
    // After this edge pair 0 is on FP_Z and pairs 1..3 are in flight.
    @(posedge clk);
    #2;
    total++;
    if (FP_Z !== 32'h40C0_0000) begin
      bad++;
      $display("FAIL async_pre: got %h want %h", FP_Z, 32'h40C0_0000);
    end
    rst = 1'b0;
    #1;
    total++;
    if (FP_Z !== 32'h0) begin
      bad++;
      $display("FAIL async_immediate: got %h want %h", FP_Z, 32'h0);
    end
    @(posedge clk);
    @(negedge clk);
    total++;
    if (FP_Z !== 32'h0) begin
      bad++;
      $display("FAIL async_held: got %h want %h", FP_Z, 32'h0);
    end
    FP_A = 32'h3FC0_0000;
    FP_B = 32'h4000_0000;
    rst  = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      total++;
      if (c < 4) begin
        if (FP_Z !== 32'h0) begin
          bad++;
          $display("FAIL async_stale[%0d]: got %h want %h", c, FP_Z, 32'h0);
        end
      end else if (FP_Z !== 32'h4040_0000) begin
        bad++;
        $display("FAIL async_first: got %h want %h", FP_Z, 32'h4040_0000);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sign_round();
    test_specials();
    test_range();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
